// File: rtl/rv_trace_buf.sv
// rv_trace_buf: retire-trace circular buffer with a 32-bit valid/ready read-out stream.
// Each retired instruction is captured as one record: W0 = {pc, reg_write}, W1 = instr,
// W2 = rd data (or 0), plus W3 = capture timestamp when RV_TRACE_BUF_TSTAMP_EN is defined.
// The reader pops the head record into a shadow register and streams it word by word.
//
// Ports:
//   i_clk, i_reset_n        clock, synchronous active-low reset
//   i_retire_valid, i_pc, i_instr, i_reg_write, i_reg_data   retire capture inputs
//   i_freeze                drops retires while high
//   i_ovf_clr               clears o_overflow (a same-cycle overwrite wins)
//   o_rd_valid, i_rd_ready, o_rd_data, o_rd_last             read-out stream
//   o_count                 records buffered, excluding the one being streamed
//   o_overflow              sticky overwrite flag
//
// Optional feature macro: RV_TRACE_BUF_TSTAMP_EN (per-record 32-bit cycle timestamp as W3).
module rv_trace_buf #(
    parameter int unsigned IADDR_SPACE_BITS = 32,
    parameter int unsigned DEPTH_LOG2       = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_retire_valid,
    input  logic [IADDR_SPACE_BITS-2:0] i_pc,
    input  logic [31:0]                 i_instr,
    input  logic                        i_reg_write,
    input  logic [31:0]                 i_reg_data,
    input  logic                        i_freeze,
    input  logic                        i_ovf_clr,
    output logic                        o_rd_valid,
    input  logic                        i_rd_ready,
    output logic [31:0]                 o_rd_data,
    output logic                        o_rd_last,
    output logic [DEPTH_LOG2:0]         o_count,
    output logic                        o_overflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned PW    = DEPTH_LOG2;

    typedef struct packed {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
`ifdef RV_TRACE_BUF_TSTAMP_EN
        logic [31:0] w3;
`endif
    } rec_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND0,
        S_SEND1,
        S_SEND2
`ifdef RV_TRACE_BUF_TSTAMP_EN
        , S_SEND3
`endif
    } state_t;

`ifdef RV_TRACE_BUF_TSTAMP_EN
    localparam state_t S_LAST = S_SEND3;
`else
    localparam state_t S_LAST = S_SEND2;
`endif

    rec_t            mem [DEPTH];
    rec_t            shadow_q;
    rec_t            shadow_d;
    rec_t            rec_new_c;
    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            pop_c;
    logic            push_c;
    logic            full_c;
    logic            ovw_c;
    logic            rd_valid_d;
    logic            rd_last_d;
    logic [31:0]     rd_data_d;
`ifdef RV_TRACE_BUF_TSTAMP_EN
    logic [31:0]     tstamp_q;
`endif

    assign o_count = count_q;

    // Record assembly from the writeback stage
    always_comb begin : rec_build
        rec_new_c    = '0;
        rec_new_c.w0 = 32'({i_pc, i_reg_write});
        rec_new_c.w1 = i_instr;
        rec_new_c.w2 = i_reg_write ? i_reg_data : 32'h0;
`ifdef RV_TRACE_BUF_TSTAMP_EN
        rec_new_c.w3 = tstamp_q;
`endif
    end

    // Capture/overwrite decisions and occupancy arithmetic
    always_comb begin : occupancy
        push_c  = i_retire_valid & ~i_freeze;
        full_c  = (count_q == CW'(DEPTH));
        // A pop in the same cycle frees the head slot, so a full capture then overwrites nothing
        ovw_c   = push_c & full_c & ~pop_c;
        count_d = count_q;
        if (push_c && !pop_c && !full_c) begin
            count_d = count_q + CW'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CW'(1);
        end
    end

    // Reader FSM: next state, pop decision and next registered stream outputs
    always_comb begin : reader_next
        state_d    = state_q;
        pop_c      = 1'b0;
        shadow_d   = shadow_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        rd_data_d  = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop_c   = 1'b1;
                    state_d = S_SEND0;
                end
            end
            S_SEND0: if (i_rd_ready) state_d = S_SEND1;
            S_SEND1: if (i_rd_ready) state_d = S_SEND2;
`ifdef RV_TRACE_BUF_TSTAMP_EN
            S_SEND2: if (i_rd_ready) state_d = S_SEND3;
            S_SEND3: begin
`else
            S_SEND2: begin
`endif
                // Last word accepted: chain straight into the next record when one is waiting
                if (i_rd_ready) begin
                    if (count_q != '0) begin
                        pop_c   = 1'b1;
                        state_d = S_SEND0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop_c) begin
            shadow_d = mem[head_q];
        end

        rd_valid_d = (state_d != S_IDLE);
        rd_last_d  = (state_d == S_LAST);
        case (state_d)
            S_SEND0: rd_data_d = shadow_d.w0;
            S_SEND1: rd_data_d = shadow_d.w1;
            S_SEND2: rd_data_d = shadow_d.w2;
`ifdef RV_TRACE_BUF_TSTAMP_EN
            S_SEND3: rd_data_d = shadow_d.w3;
`endif
            default: rd_data_d = 32'h0;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk) begin : state_reg
        if (!i_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointers, occupancy, shadow record and registered stream outputs
    always_ff @(posedge i_clk) begin : datapath_reg
        if (!i_reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            shadow_q   <= '0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= 32'h0;
            o_rd_last  <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (push_c) begin
                tail_q <= tail_q + PW'(1);
            end
            if (pop_c || ovw_c) begin
                head_q <= head_q + PW'(1);
            end
            count_q    <= count_d;
            shadow_q   <= shadow_d;
            o_rd_valid <= rd_valid_d;
            o_rd_data  <= rd_data_d;
            o_rd_last  <= rd_last_d;
            if (ovw_c) begin
                o_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                o_overflow <= 1'b0;
            end
        end
    end

    // Record storage; no reset needed since occupancy gates every read
    always_ff @(posedge i_clk) begin : mem_write
        if (i_reset_n && push_c) begin
            mem[tail_q] <= rec_new_c;
        end
    end

`ifdef RV_TRACE_BUF_TSTAMP_EN
    // Free-running capture timestamp
    always_ff @(posedge i_clk) begin : tstamp_reg
        if (!i_reset_n) begin
            tstamp_q <= 32'h0;
        end else begin
            tstamp_q <= tstamp_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rv_trace_buf.sv
// Self-checking bench for rv_trace_buf (built with DEPTH_LOG2=2 so overflow is easy to reach).
module tb_rv_trace_buf;

    localparam int unsigned IAB   = 32;
    localparam int unsigned DL2   = 2;
    localparam int unsigned DEPTH = 1 << DL2;
`ifdef RV_TRACE_BUF_TSTAMP_EN
    localparam int NW = 4;
`else
    localparam int NW = 3;
`endif

    logic            i_clk;
    logic            i_reset_n;
    logic            i_retire_valid;
    logic [IAB-2:0]  i_pc;
    logic [31:0]     i_instr;
    logic            i_reg_write;
    logic [31:0]     i_reg_data;
    logic            i_freeze;
    logic            i_ovf_clr;
    logic            o_rd_valid;
    logic            i_rd_ready;
    logic [31:0]     o_rd_data;
    logic            o_rd_last;
    logic [DL2:0]    o_count;
    logic            o_overflow;

    rv_trace_buf #(.IADDR_SPACE_BITS(IAB), .DEPTH_LOG2(DL2)) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_retire_valid (i_retire_valid),
        .i_pc           (i_pc),
        .i_instr        (i_instr),
        .i_reg_write    (i_reg_write),
        .i_reg_data     (i_reg_data),
        .i_freeze       (i_freeze),
        .i_ovf_clr      (i_ovf_clr),
        .o_rd_valid     (o_rd_valid),
        .i_rd_ready     (i_rd_ready),
        .o_rd_data      (o_rd_data),
        .o_rd_last      (o_rd_last),
        .o_count        (o_count),
        .o_overflow     (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a FIFO of whole records, the record on the wire and its word index
    typedef struct packed {
        logic [3:0][31:0] w;
    } mrec_t;
    mrec_t        mq[$];
    mrec_t        cur;
    int           widx = -1;
    bit           movf = 1'b0;
    logic [31:0]  mts  = 32'h0;
    logic [31:0]  acc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_update();
        bit    acc_last;
        bit    pop;
        bit    ovw;
        int    pre;
        mrec_t r;
        if (!i_reset_n) begin
            mq.delete();
            widx = -1;
            movf = 1'b0;
            mts  = 32'h0;
            return;
        end
        pre      = mq.size();
        acc_last = (widx == NW - 1) && i_rd_ready;
        pop      = ((widx < 0) || acc_last) && (pre > 0);
        if (widx >= 0 && i_rd_ready) widx = acc_last ? -1 : widx + 1;
        if (pop) begin
            cur  = mq.pop_front();
            widx = 0;
        end
        ovw = 1'b0;
        if (i_retire_valid && !i_freeze) begin
            r      = '0;
            r.w[0] = {i_pc, 1'b0} + 32'(i_reg_write);
            r.w[1] = i_instr;
            r.w[2] = i_reg_write ? i_reg_data : 32'h0;
            r.w[3] = mts;
            if (pre == DEPTH && !pop) begin
                void'(mq.pop_front());
                ovw = 1'b1;
            end
            mq.push_back(r);
        end
        if (ovw) movf = 1'b1;
        else if (i_ovf_clr) movf = 1'b0;
        mts = mts + 32'd1;
    endtask

    // One clock: advance the model, let the DUT clock, compare everything
    task automatic step();
        bit          stall;
        logic [31:0] pd;
        logic        pl;
        stall = o_rd_valid && !i_rd_ready && i_reset_n;
        pd    = o_rd_data;
        pl    = o_rd_last;
        if (o_rd_valid && i_rd_ready && i_reset_n) acc_q.push_back(o_rd_data);
        model_update();
        @(posedge i_clk);
        #1;
        chk("valid", 32'(o_rd_valid), 32'(widx >= 0));
        chk("last", 32'(o_rd_last), 32'(widx == NW - 1));
        chk("count", 32'(o_count), 32'(mq.size()));
        chk("overflow", 32'(o_overflow), 32'(movf));
        if (widx >= 0) chk("data", o_rd_data, cur.w[widx]);
        if (stall) begin
            chk("stall_data", o_rd_data, pd);
            chk("stall_last", 32'(o_rd_last), 32'(pl));
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                         input bit rw, input logic [31:0] d);
        i_retire_valid = v;
        i_pc           = pc[IAB-1:1];
        i_instr        = ins;
        i_reg_write    = rw;
        i_reg_data     = d;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        i_freeze  = 1'b0;
        i_ovf_clr = 1'b0;
        step();
        step();
        i_reset_n = 1'b1;
        acc_q.delete();
    endtask

    typedef struct {
        bit          v;
        logic [31:0] pc;
        logic [31:0] ins;
        bit          rw;
        logic [31:0] d;
        bit          e_valid;
        logic [31:0] e_data;
        bit          e_last;
        int          e_count;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // Single load-type retire then a store-type retire, reader always ready
        tbl[0] = '{1, 32'h100,  32'h00A00093, 1, 32'h0000000A, 0, 32'h0,        0, 1};
        tbl[1] = '{0, 32'h0,    32'h0,        0, 32'h0,        1, 32'h00000101, 0, 0};
        tbl[2] = '{0, 32'h0,    32'h0,        0, 32'h0,        1, 32'h00A00093, 0, 0};
        tbl[3] = '{0, 32'h0,    32'h0,        0, 32'h0,        1, 32'h0000000A, 1, 0};
        tbl[4] = '{0, 32'h0,    32'h0,        0, 32'h0,        0, 32'h0,        0, 0};
        tbl[5] = '{1, 32'h2000, 32'h00112023, 0, 32'hDEADBEEF, 0, 32'h0,        0, 1};
        tbl[6] = '{0, 32'h0,    32'h0,        0, 32'h0,        1, 32'h00002000, 0, 0};
        tbl[7] = '{0, 32'h0,    32'h0,        0, 32'h0,        1, 32'h00112023, 0, 0};
        tbl[8] = '{0, 32'h0,    32'h0,        0, 32'h0,        1, 32'h00000000, 1, 0};
        tbl[9] = '{0, 32'h0,    32'h0,        0, 32'h0,        0, 32'h0,        0, 0};

        i_rd_ready = 1'b1;
        do_reset();
        chk("reset_valid", 32'(o_rd_valid), 32'h0);
        chk("reset_data", o_rd_data, 32'h0);
        chk("reset_last", 32'(o_rd_last), 32'h0);
        chk("reset_count", 32'(o_count), 32'h0);
        chk("reset_ovf", 32'(o_overflow), 32'h0);

`ifndef RV_TRACE_BUF_TSTAMP_EN
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].pc, tbl[i].ins, tbl[i].rw, tbl[i].d);
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(o_rd_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_last", i), 32'(o_rd_last), 32'(tbl[i].e_last));
            chk($sformatf("tbl%0d_count", i), 32'(o_count), 32'(tbl[i].e_count));
            if (tbl[i].e_valid) chk($sformatf("tbl%0d_data", i), o_rd_data, tbl[i].e_data);
        end
`endif

        // Stalled reader, 6 retires into a 4-deep buffer: oldest queued record is overwritten
        do_reset();
        i_rd_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            drive(1, 32'(k * 16), 32'h13 + 32'(k), 1, 32'(k));
            step();
        end
        drive(0, 0, 0, 0, 0);
        chk("ovf_seq_count", 32'(o_count), 32'd4);
        chk("ovf_seq_flag", 32'(o_overflow), 32'd1);
        i_rd_ready = 1'b1;
        for (int k = 0; k < 6 * NW; k++) step();
        chk("ovf_seq_words", 32'(acc_q.size()), 32'(5 * NW));
        if (acc_q.size() == 5 * NW) begin
            chk("ovf_seq_w0_0", acc_q[0],      32'h11);
            chk("ovf_seq_w0_1", acc_q[NW],     32'h31);
            chk("ovf_seq_w0_2", acc_q[2 * NW], 32'h41);
            chk("ovf_seq_w0_3", acc_q[3 * NW], 32'h51);
            chk("ovf_seq_w0_4", acc_q[4 * NW], 32'h61);
        end
        i_ovf_clr = 1'b1;
        step();
        i_ovf_clr = 1'b0;
        chk("ovf_clear", 32'(o_overflow), 32'd0);

        // Full buffer with a retire in the cycle the last word is accepted
        do_reset();
        i_rd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1, 32'h200 + 32'(k * 4), 32'hA0 + 32'(k), 0, 32'h55);
            step();
        end
        drive(0, 0, 0, 0, 0);
        chk("fullpop_pre_count", 32'(o_count), 32'd4);
        i_rd_ready = 1'b1;
        for (int k = 0; k < NW - 1; k++) step();
        drive(1, 32'h300, 32'hB0, 0, 32'h0);
        step();
        drive(0, 0, 0, 0, 0);
        chk("fullpop_ovf", 32'(o_overflow), 32'd0);
        chk("fullpop_count", 32'(o_count), 32'd4);
        for (int k = 0; k < 6 * NW; k++) step();
        chk("fullpop_words", 32'(acc_q.size()), 32'(6 * NW));
        if (acc_q.size() == 6 * NW) begin
            chk("fullpop_first", acc_q[0], 32'h200);
            chk("fullpop_fifth", acc_q[4 * NW], 32'h210);
            chk("fullpop_sixth", acc_q[5 * NW], 32'h300);
        end

        // Reader toggling ready every cycle
        do_reset();
        for (int k = 0; k < 40; k++) begin
            i_rd_ready = k[0];
            if (k < 3) drive(1, 32'h400 + 32'(k * 4), 32'hC0 + 32'(k), 1, 32'(k + 100));
            else drive(0, 0, 0, 0, 0);
            step();
        end
        chk("toggle_words", 32'(acc_q.size()), 32'(3 * NW));
        if (acc_q.size() == 3 * NW) begin
            chk("toggle_w0", acc_q[0], 32'h401);
            chk("toggle_w1", acc_q[1], 32'hC0);
            chk("toggle_r2", acc_q[2 * NW], 32'h409);
        end

        // Freeze drops retires
        do_reset();
        i_rd_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1, 32'h500 + 32'(k * 4), 32'hD0, 1, 32'h1);
            step();
        end
        chk("frz_pre_count", 32'(o_count), 32'd1);
        i_freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h600 + 32'(k * 4), 32'hE0, 1, 32'h2);
            step();
            chk("frz_count", 32'(o_count), 32'd1);
            chk("frz_ovf", 32'(o_overflow), 32'd0);
        end
        i_freeze = 1'b0;
        drive(0, 0, 0, 0, 0);

        // Reset in the middle of a record
        do_reset();
        i_rd_ready = 1'b1;
        drive(1, 32'h700, 32'hF0, 1, 32'h77);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        step();
        chk("midrst_in_send1", o_rd_data, 32'hF0);
        i_reset_n = 1'b0;
        step();
        i_reset_n = 1'b1;
        chk("midrst_valid", 32'(o_rd_valid), 32'd0);
        chk("midrst_count", 32'(o_count), 32'd0);
        drive(1, 32'h800, 32'hF1, 0, 32'h0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        chk("midrst_restart_w0", o_rd_data, 32'h800);
        chk("midrst_restart_valid", 32'(o_rd_valid), 32'd1);
        for (int k = 0; k < NW; k++) step();

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 600; k++) begin
            drive($urandom_range(0, 9) < 6, $urandom, $urandom, $urandom_range(0, 1) == 1, $urandom);
            i_freeze   = $urandom_range(0, 9) == 0;
            i_ovf_clr  = $urandom_range(0, 19) == 0;
            i_rd_ready = $urandom_range(0, 1) == 1;
            step();
        end
        drive(0, 0, 0, 0, 0);
        i_freeze   = 1'b0;
        i_ovf_clr  = 1'b0;
        i_rd_ready = 1'b1;
        for (int k = 0; k < (DEPTH + 1) * NW + 2; k++) step();
        chk("drain_count", 32'(o_count), 32'd0);
        chk("drain_valid", 32'(o_rd_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rv_trace_buf.md
# rv_trace_buf

Hardware retire-trace buffer: captures one record per retired instruction from the writeback stage into a circular buffer and serializes the records to a debug reader over a 32-bit valid/ready stream. It sits beside the core as the read-out end of the retirement trace. Records are written at retire time and read back by a host or debug bridge at its own pace. Synthesizable; no simulation-only constructs.

## Interface
Parameters:
- IADDR_SPACE_BITS, 32, instruction address width; PC words are zero-extended to 32 bits.
- DEPTH_LOG2, 4, buffer holds 2^DEPTH_LOG2 records.

Ports:
- i_clk  in  1  single clock; all logic on its rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_retire_valid  in  1  one instruction retires this cycle.
- i_pc  in  IADDR_SPACE_BITS-1  PC bits [IADDR_SPACE_BITS-1:1] of the retiring instruction.
- i_instr  in  32  retiring instruction word.
- i_reg_write  in  1  retiring instruction writes rd.
- i_reg_data  in  32  value written to rd.
- i_freeze  in  1  capture disabled while high.
- i_ovf_clr  in  1  clears o_overflow.
- o_rd_valid  out  1  o_rd_data holds a valid word.
- i_rd_ready  in  1  reader accepts the word.
- o_rd_data  out  32  stream word.
- o_rd_last  out  1  last word of the current record.
- o_count  out  DEPTH_LOG2+1  records stored in the buffer, excluding the record being sent.
- o_overflow  out  1  sticky: one or more records were overwritten.

## Operation
- Record fields: W0 = {pc zero-extended, bit0 = i_reg_write}. W1 = instr. W2 = i_reg_write ? i_reg_data : 0.
- Capture: when i_retire_valid & !i_freeze, the record is written at the tail and the tail increments modulo depth.
- Capture while i_freeze is high: retires are dropped. No count change, no overflow.
- Full buffer on capture:
  - If no pop happens in the same cycle, the oldest entry is overwritten: head and tail both advance, count is unchanged, o_overflow is set.
  - If a pop happens in the same cycle, there is no overwrite and no overflow.
- Pop: the record is copied from the head into a shadow register, then head increments. The record being streamed therefore can never be overwritten.
- Reader FSM states: IDLE, SEND0, SEND1, SEND2 (SEND3 with the timestamp option).
  - IDLE: if count>0, pop and go to SEND0.
  - SENDk: o_rd_valid=1 and o_rd_data=Wk. On valid&ready, advance to the next word.
  - Last word accepted: if count>0, pop and go to SEND0 directly (no bubble). Otherwise go to IDLE.
- o_rd_data and o_rd_last must hold stable while valid & !ready.
- Count arithmetic: push only → +1. Pop only → −1. Push and pop together → unchanged. Pointers are DEPTH_LOG2 bits and wrap naturally.
- o_overflow: set takes priority over i_ovf_clr in the same cycle.
- Reset values: o_rd_valid=0, o_rd_data=0, o_rd_last=0, o_count=0, o_overflow=0. Pointers are 0, FSM is in IDLE.
- Reset mid-record: the partial record is discarded and the stream restarts clean.

## Timing
- Retire captured at edge N → o_count reflects it after N.
- In IDLE, pop happens at edge N+1 → o_rd_valid=1 with W0 after N+1. Minimum retire-to-first-word latency is 2 cycles.
- One word per cycle when i_rd_ready is held high. A back-to-back record stream has no gaps.
- Capture throughput is 1 record per cycle, independent of the reader.
- o_rd_last is high only in the final SEND state.

## Configuration
- RV_TRACE_BUF_TSTAMP_EN defined:
  - A free-running 32-bit cycle counter runs, reset to 0 and wrapping at 2^32.
  - Its value at capture is stored per record and sent as W3. o_rd_last is asserted on W3.
- RV_TRACE_BUF_TSTAMP_EN undefined:
  - No counter and no per-record timestamp storage.
  - Records are 3 words; o_rd_last is asserted on W2.

## Test plan
- Single retire: pc=0x100, instr=0x00A00093, reg_write=1, data=0xA, reader ready.
  - Required stream: 0x00000101, 0x00A00093, 0x0000000A, with last set on the final word. Latency is 2 cycles.
- Store-type retire: reg_write=0, data=0xDEADBEEF.
  - Required: W0 bit0=0 and W2=0.
- DEPTH_LOG2=2, reader stalled, 6 retires with pc=0x10..0x60.
  - Required: o_count saturates at 4 and o_overflow=1.
  - Required readout: one record is already in the shadow, so records 0x10, 0x30, 0x40, 0x50, 0x60 come out in order.
- Full buffer, retire in the same cycle the reader pops.
  - Required: o_overflow stays 0 and no record is lost.
- Reader toggling ready every cycle.
  - Required: data and last stable during stalls, and the word order matches.
- i_freeze high during 3 retires.
  - Required: o_count stays unchanged and o_overflow stays 0.
- Reset asserted mid-record (during SEND1).
  - Required: the next cycle shows valid=0 and count=0, and the next record streams from W0.
